iwram_arbiter: RTL

//  Two-port arbiter/sequencer in front of the 16K x 32 internal work RAM (IWRAM).

---
 rtl/iwram_arb_pkg.sv | 33 +++
 rtl/iwram_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/iwram_arb_pkg.sv
// Shared types and helpers for the IWRAM arbiter: FSM states, grant encodings
// and the byte-lane merge used by read-modify-write.
package iwram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    MERGE  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  // Merge helper works on a wide word; callers zero-extend and truncate.
  // This covers every data width up to MERGE_W.
  localparam int MERGE_W  = 256;
  localparam int MERGE_BE = MERGE_W / 8;

  function automatic logic [MERGE_W-1:0] byte_merge(
    input logic [MERGE_W-1:0]  old_word,
    input logic [MERGE_W-1:0]  new_word,
    input logic [MERGE_BE-1:0] be
  );
    logic [MERGE_W-1:0] res;
    res = old_word;
    for (int i = 0; i < MERGE_BE; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/iwram_arbiter.sv
// CPU/DMA arbiter and sequencer for the single-port IWRAM; byte-lane writes
// are done as read-modify-write because the RAM has no byte enables.
//
//   state  | meaning
//   IDLE   | wait for a request, pick the winner and latch its command
//   ACCESS | drive address, capture read data; full writes are written here
//   MERGE  | write back old word with the enabled byte lanes replaced
//   DONE   | one-cycle ack to the granted side, read data presented
module iwram_arbiter
  import iwram_arb_pkg::*;
#(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic                clock,
  input  logic                reset_n,

  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic [DATA_W/8-1:0] cpu_be,
  output logic                cpu_ack,
  output logic [DATA_W-1:0]   cpu_rdata,

  input  logic                dma_req,
  input  logic                dma_we,
  input  logic [ADDR_W-1:0]   dma_addr,
  input  logic [DATA_W-1:0]   dma_wdata,
  input  logic [DATA_W/8-1:0] dma_be,
  output logic                dma_ack,
  output logic [DATA_W-1:0]   dma_rdata,

  output logic                ram_wren,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W-1:0]   ram_data,
  input  logic [DATA_W-1:0]   ram_q
);

  localparam int BE_W = DATA_W / 8;

  state_t              state;
  state_t              state_nxt;
  logic                grant;
  logic                grant_nxt;
  logic                last_grant;
  logic                any_req;

  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [BE_W-1:0]     lat_be;
  logic [DATA_W-1:0]   hold_q;
  logic [DATA_W-1:0]   cpu_rdata_r;
  logic [DATA_W-1:0]   dma_rdata_r;

  logic                be_full;
  logic                be_none;
  logic                partial_wr;
  logic [DATA_W-1:0]   merged;

  assign any_req    = cpu_req | dma_req;
  assign be_full    = &lat_be;
  assign be_none    = ~|lat_be;
  assign partial_wr = lat_we & ~be_full & ~be_none;

  // Tie-break: fixed mode always favours DMA, otherwise alternate.
  always_comb begin
    grant_nxt = REQ_CPU;
    if (cpu_req && dma_req) begin
      grant_nxt = (FIXED_PRIO != 0) ? REQ_DMA : ~last_grant;
    end else if (dma_req) begin
      grant_nxt = REQ_DMA;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  state_nxt = partial_wr ? MERGE : DONE;
      MERGE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command latch: the winner's fields are frozen for the whole transaction.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      grant      <= REQ_CPU;
      last_grant <= REQ_DMA;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_be     <= '0;
    end else if (state == IDLE && any_req) begin
      grant      <= grant_nxt;
      last_grant <= grant_nxt;
      if (grant_nxt == REQ_DMA) begin
        lat_we    <= dma_we;
        lat_addr  <= dma_addr;
        lat_wdata <= dma_wdata;
        lat_be    <= dma_be;
      end else begin
        lat_we    <= cpu_we;
        lat_addr  <= cpu_addr;
        lat_wdata <= cpu_wdata;
        lat_be    <= cpu_be;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_q      <= '0;
      cpu_rdata_r <= '0;
      dma_rdata_r <= '0;
    end else if (state == ACCESS) begin
      hold_q <= ram_q;
      if (!lat_we) begin
        if (grant == REQ_DMA) dma_rdata_r <= ram_q;
        else                  cpu_rdata_r <= ram_q;
      end
    end
  end

  assign merged = DATA_W'(byte_merge(MERGE_W'(hold_q), MERGE_W'(lat_wdata),
                                     MERGE_BE'(lat_be)));

  // Address only moves at grant, so it holds its last value between accesses.
  assign ram_address = lat_addr;
  assign cpu_rdata   = cpu_rdata_r;
  assign dma_rdata   = dma_rdata_r;

  always_comb begin
    ram_wren = 1'b0;
    ram_data = '0;
    cpu_ack  = 1'b0;
    dma_ack  = 1'b0;
    unique case (state)
      ACCESS: begin
        if (lat_we && be_full) begin
          ram_wren = 1'b1;
          ram_data = lat_wdata;
        end
      end
      MERGE: begin
        ram_wren = 1'b1;
        ram_data = merged;
      end
      DONE: begin
        cpu_ack = (grant == REQ_CPU);
        dma_ack = (grant == REQ_DMA);
      end
      default: ;
    endcase
  end

endmodule
